// File: rtl/avg_chan_scheduler_pkg.sv
// Shared types and helpers for the channel-multiplexed averaging decimator.
package avg_sched_pkg;

    typedef enum logic {RUN, FLUSH} state_e;

    localparam int unsigned DEF_MAX_SHIFT = 6;

    function automatic int unsigned ch_w(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Terminal count for a block of 2^shift samples.
    function automatic logic [7:0] len_mask(input logic [2:0] shift);
        return (8'd1 << shift) - 8'd1;
    endfunction

endpackage

// File: rtl/avg_chan_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request found searching from ptr+1.
module rr_arbiter
    import avg_sched_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [ch_w(NCH)-1:0]   ptr,
    output logic [NCH-1:0]         grant,
    output logic [ch_w(NCH)-1:0]   grant_idx,
    output logic                   any
);

    localparam int unsigned CH_W = ch_w(NCH);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = (32'(ptr) + k) % NCH;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/avg_chan_scheduler.sv
// Round-robin shared averaging decimator over NCH channels.
// Define AVG_ROUND_EN for round-half-up (saturating) output instead of truncation.
module avg_chan_scheduler
    import avg_sched_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned DW        = 24,
    parameter int unsigned MAX_SHIFT = DEF_MAX_SHIFT,
    parameter int unsigned ACC_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*DW-1:0]        ch_data,
    input  logic [NCH-1:0]           ch_valid,
    output logic [NCH-1:0]           ch_ready,
    input  logic [2:0]               cfg_shift,
    input  logic                     cfg_update,
    output logic [DW-1:0]            avg_data,
    output logic [$clog2(NCH)-1:0]   avg_ch,
    output logic                     avg_valid,
    output logic                     busy_flush
);

    localparam int unsigned CH_W      = ch_w(NCH);
    localparam logic [2:0]  SHIFT_CAP = 3'(MAX_SHIFT);

    if (ACC_W < DW + MAX_SHIFT) begin : g_acc_chk
        $error("ACC_W must be >= DW + MAX_SHIFT");
    end
    if (MAX_SHIFT > 7) begin : g_shift_chk
        $error("MAX_SHIFT must fit the 3-bit cfg_shift range");
    end

    state_e           state;
    logic [CH_W-1:0]  ptr;
    logic [2:0]       shift_q;
    logic [2:0]       shift_pend;
    logic [ACC_W-1:0] acc [NCH];
    logic [7:0]       cnt [NCH];

    logic [NCH-1:0]   grant;
    logic [CH_W-1:0]  grant_idx;
    logic             any;
    logic [DW-1:0]    sel_data;
    logic [ACC_W-1:0] sum;
    logic [DW-1:0]    avg_next;
    logic [2:0]       shift_req;
    logic [2:0]       shift_new;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req       (ch_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign ch_ready = (state == RUN) ? grant : '0;

`ifdef AVG_ROUND_EN
    logic [ACC_W:0] rnd_add;
    logic [ACC_W:0] rnd_shr;
`endif

    always_comb begin
        sel_data  = ch_data[grant_idx*DW +: DW];
        sum       = acc[grant_idx] + ACC_W'(sel_data);
        // An update arriving during FLUSH overrides the value latched earlier.
        shift_req = cfg_update ? cfg_shift : shift_pend;
        shift_new = (shift_req > SHIFT_CAP) ? SHIFT_CAP : shift_req;
`ifdef AVG_ROUND_EN
        rnd_add  = (shift_q == 3'd0) ? '0 : ((ACC_W+1)'(1) << (shift_q - 3'd1));
        rnd_shr  = ({1'b0, sum} + rnd_add) >> shift_q;
        avg_next = (|rnd_shr[ACC_W:DW]) ? '1 : rnd_shr[DW-1:0];
`else
        avg_next = DW'(sum >> shift_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            ptr        <= CH_W'(NCH - 1);
            shift_q    <= '0;
            shift_pend <= '0;
            avg_data   <= '0;
            avg_ch     <= '0;
            avg_valid  <= 1'b0;
            busy_flush <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            avg_valid <= 1'b0;
            if (cfg_update) shift_pend <= cfg_shift;
            case (state)
                RUN: begin
                    if (any) begin
                        ptr <= grant_idx;
                        if (cnt[grant_idx] == len_mask(shift_q)) begin
                            avg_data       <= avg_next;
                            avg_ch         <= grant_idx;
                            avg_valid      <= 1'b1;
                            acc[grant_idx] <= '0;
                            cnt[grant_idx] <= '0;
                        end else begin
                            acc[grant_idx] <= sum;
                            cnt[grant_idx] <= cnt[grant_idx] + 8'd1;
                        end
                    end
                    if (cfg_update) begin
                        state      <= FLUSH;
                        busy_flush <= 1'b1;
                    end
                end
                FLUSH: begin
                    for (int unsigned i = 0; i < NCH; i++) begin
                        acc[i] <= '0;
                        cnt[i] <= '0;
                    end
                    shift_q    <= shift_new;
                    state      <= RUN;
                    busy_flush <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/avg_chan_scheduler.md
Name: avg_chan_scheduler

Overview:
- Shares one averaging decimator datapath among NCH input channels.
- A round-robin arbiter accepts at most one sample per clock from the requesting channels.
- Per-channel accumulators and counters average each channel over 2^shift samples.
- Outputs channel-tagged averages; sits between the ADC capture channels and the downstream filter stage. Decimation length reconfiguration flushes all channels safely.

Parameters:
NCH, 4, number of input channels (2..8)
DW, 24, sample width, unsigned
MAX_SHIFT, 6, largest log2 averaging length (64 samples)
ACC_W, 32, accumulator width; must be >= DW+MAX_SHIFT

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ch_data  in  NCH*DW  channel samples, channel i at bits [i*DW +: DW]
ch_valid  in  NCH  per-channel sample valid; must not depend on ch_ready
ch_ready  out  NCH  per-channel accept, one-hot or zero
cfg_shift  in  3  requested log2 averaging length
cfg_update  in  1  one-cycle pulse: apply cfg_shift
avg_data  out  DW  averaged sample
avg_ch  out  $clog2(NCH)  channel id of avg_data
avg_valid  out  1  one-cycle strobe, avg_data/avg_ch valid
busy_flush  out  1  high during FLUSH state

Behaviour:
- Reset: all outputs 0, all acc/cnt 0, active shift = 0, rr pointer = NCH-1, state RUN.
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- States:
  - RUN: arbitrate and accumulate.
  - FLUSH: one cycle; ch_ready = 0; every acc/cnt cleared; active shift <= min(latched cfg_shift, MAX_SHIFT); then back to RUN.
- cfg_update in RUN: latch cfg_shift and go to FLUSH next cycle. A transfer in that same cycle completes normally, but its partial sum is discarded by FLUSH.
- cfg_update during FLUSH: latch the new cfg_shift; it is the value applied at the FLUSH exit.
- Arbitration (combinational): grant the first asserted ch_valid searching from ptr+1 modulo NCH. ch_ready = grant in RUN, else 0. On a transfer (valid & ready), ptr <= granted index. No request: ptr unchanged.
- Accumulate on transfer for channel i:
  - If cnt[i] == (1<<shift)-1: avg_data <= (acc[i]+data) >> shift, truncated to DW; avg_ch <= i; avg_valid <= 1; acc[i] <= 0; cnt[i] <= 0.
  - Else: acc[i] += data; cnt[i] += 1.
- Latency: avg_valid is asserted 1 cycle after the final sample's transfer. It is 0 on every cycle without a completing transfer.
- shift = 0: every sample passes through unchanged, latency 1.
- No overflow is possible (ACC_W >= DW+MAX_SHIFT); parameter check at elaboration.
- Throughput: 1 sample/clk aggregate. Each continuously-valid channel gets 1/NCH of cycles.
- avg_data/avg_ch hold their last value when avg_valid = 0.

Optional Feature:
- AVG_ROUND_EN defined: the output is (acc+data + (1<<(shift-1))) >> shift for shift > 0, i.e. round-half-up, saturated to 2^DW-1.
- Undefined: truncation as above.
- shift = 0 is unaffected either way.

Decomposition:
- Package avg_sched_pkg:
  - state enum {RUN, FLUSH}
  - MAX_SHIFT constant
  - function clog2-based CH_W
  - function computing the length mask (1<<shift)-1
- Sub-module rr_arbiter (NCH param; inputs req, ptr; outputs grant one-hot, grant_idx, any). It is purely combinational; ptr update stays in the parent.

Test Plan:
- shift=2, only ch0 valid, data 10,20,30,40 → one avg_valid, avg_ch=0, avg_data=25, 1 cycle after the 4th transfer.
- shift=1, all 4 channels valid every cycle, ch i data = 100*(i+1) constant:
  - ch_ready rotates 0,1,2,3.
  - Outputs ch0..ch3 = 100,200,300,400, each every 8 cycles.
- shift=0, ch2 data 0xFFFFFF → avg_data 0xFFFFFF, avg_ch=2 each transfer; shift=6 with 64×0xFFFFFF → 0xFFFFFF (no overflow).
- shift=2, ch1 has 2 of 4 samples, then cfg_update with cfg_shift=1 → busy_flush one cycle, ch_ready=0. Ch1 restarts: next 2 samples 6,8 → avg_data=7.
- cfg_shift=7 → clamped to 6; 64 samples of 1 required before avg_valid, output 1.
- AVG_ROUND_EN, shift=1, samples 1,2 → 2 (truncate build → 1); rst asserted mid-block → all outputs 0 next cycle, counters restart.
